// File: rtl/fft_pkg.sv
// fft_pkg: definitions shared by the radix-2 FFT stage blocks
// (delay line and pair serializer).
//   DATA_W      - default sample width in bits
//   HALF        - default pairs per frame, which is also the pair distance
//   data_t      - sample type at the default width
//   ser_state_t - pair serializer phases: FILL (collect pairs),
//                 DRAIN (replay the buffered lower results)
package fft_pkg;

   localparam int DATA_W = 32;
   localparam int HALF   = 32;

   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } ser_state_t;

endpackage

// File: rtl/pair_buf.sv
// pair_buf: DEPTH x DATA_W register array that holds the lower butterfly
// results of one frame until they are replayed.
//   clk           - clock, rising edge
//   we            - write enable
//   waddr, wdata  - synchronous write port
//   raddr, rdata  - asynchronous read port
// The contents are never reset. Every location is written before it is
// read within a frame, so stale data is never observed.
module pair_buf #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_reg [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

   assign rdata = mem_reg[raddr];

endmodule

// File: rtl/pair_serializer.sv
// pair_serializer: takes butterfly result pairs (upper a, lower b, for
// samples HALF apart) and re-serializes them into one sample per cycle.
// Within a frame all HALF a samples leave first (as they arrive), then all
// HALF b samples in arrival order.
//   clk        - clock, rising edge
//   nrst       - asynchronous active-low reset
//   in_valid   - pair on in_a/in_b is valid
//   in_ready   - pair is accepted this cycle (high only while filling)
//   in_a       - upper butterfly output
//   in_b       - lower butterfly output
//   out_valid  - out_data is valid (no backpressure downstream)
//   out_data   - serialized sample
//   out_sof    - (PAIR_SER_FRAME_EN only) high with a_0
//   out_eof    - (PAIR_SER_FRAME_EN only) high with b_{HALF-1}
// Defining PAIR_SER_FRAME_EN adds the out_sof/out_eof frame markers.
module pair_serializer #(
   parameter int DATA_W = fft_pkg::DATA_W,
   parameter int HALF   = fft_pkg::HALF
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
`ifdef PAIR_SER_FRAME_EN
   ,
   output logic              out_sof,
   output logic              out_eof
`endif
);

   import fft_pkg::*;

   localparam int            CW   = $clog2(HALF);
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   ser_state_t        state_reg;
   logic [CW-1:0]     cnt_reg;
   logic              out_valid_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic [DATA_W-1:0] buf_rdata;
   logic              xfer;
   logic              cnt_last;

   // in_ready depends only on state so upstream never sees a loop via in_valid.
   assign in_ready = (state_reg == FILL);
   assign xfer     = in_valid & in_ready;
   assign cnt_last = (cnt_reg == LAST);

   // During FILL cnt is the write slot, during DRAIN the read slot, so a
   // single counter keeps the b samples in arrival order.
   pair_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (HALF),
      .AW     (CW)
   ) u_buf (
      .clk    (clk),
      .we     (xfer),
      .waddr  (cnt_reg),
      .wdata  (in_b),
      .raddr  (cnt_reg),
      .rdata  (buf_rdata)
   );

`ifdef PAIR_SER_FRAME_EN
   logic out_sof_reg;
   logic out_eof_reg;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         out_sof_reg <= 1'b0;
         out_eof_reg <= 1'b0;
      end else if (state_reg == FILL) begin
         // Markers only rise on valid output cycles.
         out_sof_reg <= xfer & (cnt_reg == '0);
         out_eof_reg <= 1'b0;
      end else begin
         out_sof_reg <= 1'b0;
         out_eof_reg <= cnt_last;
      end
   end

   assign out_sof = out_sof_reg;
   assign out_eof = out_eof_reg;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg     <= FILL;
         cnt_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else if (state_reg == FILL) begin
         if (xfer) begin
            out_data_reg  <= in_a;
            out_valid_reg <= 1'b1;
            if (cnt_last) begin
               state_reg <= DRAIN;
               cnt_reg   <= '0;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end else begin
            // Gap: data holds, only valid drops.
            out_valid_reg <= 1'b0;
         end
      end else begin
         // Drain runs every cycle regardless of the input side.
         out_data_reg  <= buf_rdata;
         out_valid_reg <= 1'b1;
         if (cnt_last) begin
            state_reg <= FILL;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;

endmodule

// File: tb/tb_pair_serializer.sv
// Directed self-checking bench for pair_serializer with HALF = 4.
module tb_pair_serializer;

   localparam int DW = 32;
   localparam int HF = 4;

   logic          clk;
   logic          nrst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic          out_valid;
   logic [DW-1:0] out_data;
`ifdef PAIR_SER_FRAME_EN
   logic          out_sof;
   logic          out_eof;
`endif

   int checks = 0;
   int errors = 0;

   pair_serializer #(
      .DATA_W (DW),
      .HALF   (HF)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_data  (out_data)
`ifdef PAIR_SER_FRAME_EN
      ,
      .out_sof   (out_sof),
      .out_eof   (out_eof)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_marks(input logic sof, input logic eof);
`ifdef PAIR_SER_FRAME_EN
      chk("out_sof", DW'(out_sof), DW'(sof));
      chk("out_eof", DW'(out_eof), DW'(eof));
`else
      if (sof === 1'bx || eof === 1'bx) $display("marker arguments unknown");
`endif
   endtask

   // One full frame: a_i = a0+i, b_i = b0+i. With gaps, an idle cycle
   // precedes every pair.
   task automatic run_frame(input int a0, input int b0, input bit gaps);
      for (int i = 0; i < HF; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            tick();
            $display("gap   : out_valid=%0d in_ready=%0d", out_valid, in_ready);
            chk("gap_out_valid", DW'(out_valid), DW'(0));
            chk("gap_in_ready", DW'(in_ready), DW'(1));
            chk_marks(1'b0, 1'b0);
         end
         in_valid = 1'b1;
         in_a     = DW'(a0 + i);
         in_b     = DW'(b0 + i);
         tick();
         $display("fill  : out_valid=%0d out_data=%0d in_ready=%0d", out_valid, out_data, in_ready);
         chk("fill_out_valid", DW'(out_valid), DW'(1));
         chk("fill_out_data", out_data, DW'(a0 + i));
         chk("fill_in_ready", DW'(in_ready), DW'(i < HF - 1));
         chk_marks(i == 0, 1'b0);
      end
      // Input held valid with junk: must be ignored while draining.
      in_a = DW'(32'hdead);
      in_b = DW'(32'hbeef);
      for (int j = 0; j < HF; j++) begin
         tick();
         $display("drain : out_valid=%0d out_data=%0d in_ready=%0d", out_valid, out_data, in_ready);
         chk("drain_out_valid", DW'(out_valid), DW'(1));
         chk("drain_out_data", out_data, DW'(b0 + j));
         chk("drain_in_ready", DW'(in_ready), DW'(j == HF - 1));
         chk_marks(1'b0, j == HF - 1);
      end
   endtask

   initial begin
      nrst     = 1'b0;
      in_valid = 1'b1;
      in_a     = DW'(99);
      in_b     = DW'(199);

      // Reset held with in_valid high.
      tick();
      tick();
      $display("reset : out_valid=%0d out_data=%0d in_ready=%0d", out_valid, out_data, in_ready);
      chk("rst_out_valid", DW'(out_valid), DW'(0));
      chk("rst_out_data", out_data, DW'(0));
      chk("rst_in_ready", DW'(in_ready), DW'(1));
      chk_marks(1'b0, 1'b0);
      nrst = 1'b1;

      // Continuous frame then a back-to-back frame (first pair accepted on
      // the first edge after release).
      run_frame(1, 101, 1'b0);
      run_frame(5, 105, 1'b0);

      // Gapped input.
      run_frame(1, 101, 1'b1);
      in_valid = 1'b0;
      tick();
      chk("idle_out_valid", DW'(out_valid), DW'(0));
      chk("idle_out_data_hold", out_data, DW'(104));

      // Reset mid-drain after 102 has been output.
      for (int i = 0; i < HF; i++) begin
         in_valid = 1'b1;
         in_a     = DW'(1 + i);
         in_b     = DW'(101 + i);
         tick();
         chk("md_fill_data", out_data, DW'(1 + i));
      end
      in_valid = 1'b0;
      tick();
      chk("md_drain0", out_data, DW'(101));
      tick();
      $display("drain : out_valid=%0d out_data=%0d", out_valid, out_data);
      chk("md_drain1", out_data, DW'(102));
      nrst = 1'b0;
      #1;
      $display("reset : out_valid=%0d out_data=%0d in_ready=%0d", out_valid, out_data, in_ready);
      chk("md_rst_out_valid", DW'(out_valid), DW'(0));
      chk("md_rst_out_data", out_data, DW'(0));
      chk("md_rst_in_ready", DW'(in_ready), DW'(1));
      tick();
      nrst = 1'b1;
      run_frame(9, 109, 1'b0);
      in_valid = 1'b0;
      tick();
      chk("end_out_valid", DW'(out_valid), DW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
